// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide engine
// owning the architectural HI/LO registers.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WriteData,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t state;
   state_t state_nx;

   logic [CW-1:0]      count;
   logic               is_div;
   logic               is_signed;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH-1:0]   orig_a;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               dbz_q;

   logic               start_ok;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rmd;
   logic               div_zero;

   assign start_ok = (state == IDLE) && Start;

   // Magnitudes for signed ops; 0x80000000 maps to itself.
   assign abs_a = (Op[0] && OperandA[WIDTH-1]) ? (~OperandA + 1'b1) : OperandA;
   assign abs_b = (Op[0] && OperandB[WIDTH-1]) ? (~OperandB + 1'b1) : OperandB;

   // Shift-add step: low half of acc holds the multiplier, LSB first.
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opa} : '0);

   // Restoring step: low half of acc shifts dividend out, quotient in.
   assign div_sh   = {rem, acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opb};
   assign div_ge   = ~div_diff[WIDTH];

   assign div_zero = is_div && (opb == '0);

   // Sign fix-up applied once the magnitude result is complete.
   always_comb begin
      prod = acc;
      quot = acc[WIDTH-1:0];
      rmd  = rem;
      if (is_signed && (sign_a ^ sign_b)) begin
         prod = ~acc + 1'b1;
         quot = ~acc[WIDTH-1:0] + 1'b1;
      end
      if (is_signed && sign_a) begin
         rmd = ~rem + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (Start) state_nx = CALC;
         CALC: if (count == LAST) state_nx = FIX;
         FIX:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture and one iteration per CALC cycle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count     <= '0;
         is_div    <= 1'b0;
         is_signed <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         opa       <= '0;
         opb       <= '0;
         orig_a    <= '0;
         acc       <= '0;
         rem       <= '0;
      end else if (start_ok) begin
         count     <= '0;
         is_div    <= Op[1];
         is_signed <= Op[0];
         sign_a    <= Op[0] & OperandA[WIDTH-1];
         sign_b    <= Op[0] & OperandB[WIDTH-1];
         opa       <= abs_a;
         opb       <= abs_b;
         orig_a    <= OperandA;
         acc       <= {{WIDTH{1'b0}}, (Op[1] ? abs_a : abs_b)};
         rem       <= '0;
      end else if (state == CALC) begin
         count <= count + 1'b1;
         if (is_div) begin
            rem <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
         end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
         end
      end
   end

   // HI/LO: result on FIX, MTHI/MTLO only while idle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (state == FIX) begin
         if (div_zero) begin
            hi_q <= orig_a;
            lo_q <= '1;
         end else if (is_div) begin
            hi_q <= rmd;
            lo_q <= quot;
         end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
         end
      end else if (state == IDLE) begin
         if (HiWrite) hi_q <= WriteData;
         if (LoWrite) lo_q <= WriteData;
      end
   end

   // Completion pulses for the cycle after FIX.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= (state == FIX);
         dbz_q  <= (state == FIX) && div_zero;
      end
   end

   assign Busy      = (state != IDLE);
   assign Done      = done_q;
   assign DivByZero = dbz_q;
   assign Hi        = hi_q;
   assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table plus scoreboard queue
// for the iterative multiply/divide unit.
module tb_mult_div_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [31:0] OperandA = '0;
   logic [31:0] OperandB = '0;
   logic        HiWrite = 1'b0;
   logic        LoWrite = 1'b0;
   logic [31:0] WriteData = '0;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   mult_div_unit #(.WIDTH(32)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Start(Start),
      .Op(Op),
      .OperandA(OperandA),
      .OperandB(OperandB),
      .HiWrite(HiWrite),
      .LoWrite(LoWrite),
      .WriteData(WriteData),
      .Busy(Busy),
      .Done(Done),
      .DivByZero(DivByZero),
      .Hi(Hi),
      .Lo(Lo)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   localparam int NV = 18;

   vec_t vecs[NV];
   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi,
                                 output logic [31:0] lo, output logic dbz);
      logic        [63:0] p;
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] q;
      logic signed [63:0] r;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      dbz = 1'b0;
      hi  = '0;
      lo  = '0;
      if (op == 2'b00) begin
         p  = {32'b0, a} * {32'b0, b};
         hi = p[63:32];
         lo = p[31:0];
      end else if (op == 2'b01) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         dbz = 1'b1;
         hi  = a;
         lo  = 32'hFFFF_FFFF;
      end else if (op == 2'b10) begin
         lo = a / b;
         hi = a % b;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         lo = q[31:0];
         hi = r[31:0];
      end
   endfunction

   // Drives Start in the current cycle; returns one negedge after E0.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit push,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edbz, input bit hw);
      exp_t e;
      if (push) begin
         e.hi  = ehi;
         e.lo  = elo;
         e.dbz = edbz;
         sb_q.push_back(e);
      end
      Start    = 1'b1;
      Op       = op;
      OperandA = a;
      OperandB = b;
      if (hw) begin
         HiWrite   = 1'b1;
         WriteData = 32'h0000_ABCD;
      end
      @(negedge Clock);
      Start   = 1'b0;
      HiWrite = 1'b0;
   endtask

   // Waits for Done; e0 = edges already elapsed since (and including) E0.
   task automatic wait_done(input string name, input int e0);
      int   edges;
      int   busy_n;
      bit   seen;
      bit   overlap;
      exp_t e;
      edges   = e0;
      busy_n  = e0 - 1 + int'(Busy);
      seen    = Done;
      overlap = Busy & Done;
      while (!seen && edges < 60) begin
         @(negedge Clock);
         edges++;
         busy_n += int'(Busy);
         overlap |= Busy & Done;
         seen = Done;
      end
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      check({name, "_latency"}, 64'(edges), 64'd34);
      check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
      check({name, "_busy_done_excl"}, 64'(overlap), 64'd0);
      if (sb_q.size() == 0) begin
         check({name, "_sb_nonempty"}, 64'(sb_q.size()), 64'd1);
      end else begin
         e = sb_q.pop_front();
         check({name, "_hi"}, 64'(Hi), 64'(e.hi));
         check({name, "_lo"}, 64'(Lo), 64'(e.lo));
         check({name, "_dbz"}, 64'(DivByZero), 64'(e.dbz));
      end
   endtask

   initial begin
      int n_done;

      vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007,
                  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[4] = '{2'b10, 32'd100, 32'd0,
                  32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
      vecs[5] = '{2'b11, 32'hFFFF_FFF9, 32'd0,
                  32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      vecs[6] = '{2'b01, 32'h8000_0000, 32'h8000_0000,
                  32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[7] = '{2'b10, 32'hFFFF_FFFF, 32'd3,
                  32'h0000_0000, 32'h5555_5555, 1'b0};
      vecs[8] = '{2'b11, 32'd7, 32'hFFFF_FFFE,
                  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[9] = '{2'b00, 32'h1234_5678, 32'd0,
                  32'h0000_0000, 32'h0000_0000, 1'b0};
      for (int i = 10; i < NV; i++) begin
         vecs[i].op = 2'(i % 4);
         vecs[i].a  = $urandom;
         vecs[i].b  = (i == 14) ? 32'(i) : $urandom;
         model(vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].dbz);
      end

      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_done", 64'(Done), 64'd0);
      check("rst_dbz", 64'(DivByZero), 64'd0);
      check("rst_hi", 64'(Hi), 64'd0);
      check("rst_lo", 64'(Lo), 64'd0);

      // Each op after the first starts in the previous Done cycle.
      for (int i = 0; i < NV; i++) begin
         start_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1,
                  vecs[i].hi, vecs[i].lo, vecs[i].dbz, 1'b0);
         wait_done($sformatf("vec%0d", i), 1);
      end

      // Second Start at E5 with new Op/operands is ignored.
      start_op(2'b00, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0, 1'b0);
      repeat (4) @(negedge Clock);
      Start    = 1'b1;
      Op       = 2'b10;
      OperandA = 32'd100;
      OperandB = 32'd7;
      @(negedge Clock);
      Start = 1'b0;
      wait_done("restart_ignored", 6);

      // Reset at E10 aborts with no Done.
      start_op(2'b10, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0, 1'b0);
      repeat (9) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check("abort_busy", 64'(Busy), 64'd0);
      check("abort_hi", 64'(Hi), 64'd0);
      check("abort_lo", 64'(Lo), 64'd0);
      check("abort_done", 64'(Done), 64'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock);
         n_done += int'(Done);
      end
      check("abort_no_done", 64'(n_done), 64'd0);

      start_op(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 1'b0);
      wait_done("divu_100_7", 1);

      // MTLO while idle.
      LoWrite   = 1'b1;
      WriteData = 32'h0000_1234;
      @(negedge Clock);
      LoWrite = 1'b0;
      check("mtlo_lo", 64'(Lo), 64'h1234);
      check("mtlo_hi_kept", 64'(Hi), 64'd2);

      // MTHI during CALC is dropped.
      start_op(2'b00, 32'd5, 32'd5, 1'b1, 32'd0, 32'd25, 1'b0, 1'b0);
      HiWrite   = 1'b1;
      WriteData = 32'h0000_ABCD;
      @(negedge Clock);
      HiWrite = 1'b0;
      check("mthi_busy_hi", 64'(Hi), 64'd2);
      wait_done("multu_5_5", 2);

      // MTHI with Start lands, then the product overwrites it.
      start_op(2'b00, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0, 1'b1);
      check("mthi_start_hi", 64'(Hi), 64'hABCD);
      wait_done("multu_2_3", 1);

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits directly downstream of the register file: rs/rt read data (ReadData1/ReadData2) arrive as OperandA/OperandB. Results go to HI/LO, which MFHI/MFLO read. It raises Busy so the control path can stall HI/LO-dependent instructions.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is verified.
- Clock  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- Start  input  1  begin an operation; sampled only in IDLE.
- Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start.
- OperandA  input  WIDTH  rs value; multiplicand or dividend.
- OperandB  input  WIDTH  rt value; multiplier or divisor.
- HiWrite  input  1  MTHI: Hi <= WriteData.
- LoWrite  input  1  MTLO: Lo <= WriteData.
- WriteData  input  WIDTH  MTHI/MTLO data.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result this cycle.
- DivByZero  output  1  pulses with Done when a DIV/DIVU had OperandB == 0.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

## Operation
- States are IDLE, CALC and FIX. Reset forces IDLE, count 0, Busy 0, Done 0, DivByZero 0, Hi 0, Lo 0.
- IDLE with Start=1:
  - Latch Op.
  - For signed ops, latch |OperandA| and |OperandB|, plus the sign of each.
  - For unsigned ops, latch the operands as-is.
  - Go to CALC with count 0.
  - |0x80000000| = 0x80000000 as a 32-bit unsigned value. No overflow special case.
- CALC runs one iteration per cycle for 32 cycles; count 0..31. At count 31 go to FIX.
  - Multiply is shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide is restoring, one quotient bit per cycle, MSB first. It uses a 33-bit partial remainder, and the subtract is 33 bits wide.
- FIX updates Hi/Lo, asserts Done for one cycle, and returns to IDLE.
  - MULT/MULTU: {Hi,Lo} = product. For MULT, the 64-bit product is negated if the operand signs differ.
  - DIV/DIVU: Lo = quotient, Hi = remainder. For DIV, the quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - Divisor 0 (DIV or DIVU): Lo = 0xFFFFFFFF, Hi = original OperandA, DivByZero = 1. Latency is unchanged.
- Start with Busy=1 is ignored. Op and operand changes while Busy have no effect.
- HiWrite/LoWrite in IDLE update the register at the next edge.
  - If Start is in the same cycle, the write still occurs, and the later FIX result overwrites it.
  - HiWrite/LoWrite while Busy (CALC/FIX) are ignored.
- Hi/Lo hold their value except on FIX, MTHI/MTLO or Reset.
- Reset mid-operation aborts immediately: IDLE and all outputs 0 after the edge. No Done pulse.

## Timing
- Start sampled at edge E0. Busy=1 after E0 through E33. FIX is the cycle after E32.
- Hi/Lo updated at E33. Done=1 and DivByZero (if set) for exactly the cycle after E33.
- Latency: 34 edges from Start to result. A new Start is accepted in the Done cycle, because Busy=0 then and the state is IDLE.
- Done and Busy are never high in the same cycle.
- Hi/Lo are register outputs, with no combinational path from the inputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Done exactly 34 edges after Start. Busy high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIV −7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU 100 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000064, DivByZero=1 with Done.
- Second Start at E5 during MULTU 6×7 -> ignored, result Lo=42. Reset at E10 of another op -> next cycle Busy=0, Hi=Lo=0, no Done. A following DIVU 100/7 -> Lo=14, Hi=2.
- LoWrite 0x1234 in IDLE -> Lo=0x1234 next cycle. HiWrite 0xABCD during CALC -> Hi unchanged. HiWrite with Start of MULTU 2×3 -> Hi=0xABCD after 1 cycle, then Hi=0, Lo=6 at Done.
